// File: rtl/reg_access_seq_if.sv
// Command/response handshake bundle for reg_access_seq.
//   master : command producer / response consumer (drives cmd_*, rsp_ready)
//   slave  : the sequencer (drives cmd_ready, rsp_valid, rsp_data)
// Signals
//   cmd_valid / cmd_ready  command handshake
//   cmd_op                 00 NOP, 01 WRITE, 10 READ, 11 SWAP
//   cmd_data               write data for WRITE/SWAP
//   rsp_valid / rsp_ready  response handshake
//   rsp_data               register value captured for READ/SWAP
interface reg_access_seq_if #(
  parameter int unsigned width = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [width-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [width-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/reg_access_seq.sv
// Command sequencer in front of a width-bit storage register.
// Queues WRITE/READ/SWAP commands in a DEPTH-entry FIFO, drives the register's
// r/w/ip strobes one command at a time, and returns the captured register output
// for READ/SWAP on the response handshake.
// Ports
//   clk       system clock, all logic on posedge
//   reset     synchronous active-low reset
//   bus       command/response handshake (slave side)
//   reg_r     read strobe to storage register (high only in ISSUE)
//   reg_w     write strobe to storage register (high only in ISSUE)
//   reg_ip    write data to storage register
//   reg_op    storage register output, valid the cycle after reg_r
//   busy      FSM active or FIFO not empty
//   done_cnt  completed non-NOP commands, wraps 255 -> 0
module reg_access_seq #(
  parameter int unsigned width = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  reg_access_seq_if.slave  bus,
  output logic             reg_r,
  output logic             reg_w,
  output logic [width-1:0] reg_ip,
  input  logic [width-1:0] reg_op,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpSwap  = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StResp} state_e;

  // Command FIFO
  logic [1:0]       fifo_op   [DEPTH];
  logic [width-1:0] fifo_data [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             fifo_full, fifo_empty, push, pop;

  // FSM and registered outputs
  state_e           state_q;
  logic [1:0]       op_q;
  logic             rsp_valid_q;
  logic [width-1:0] rsp_data_q;
  logic [1:0]       head_op;
  logic [width-1:0] head_data;

  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.cmd_valid && !fifo_full;
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign head_op    = fifo_op[rd_ptr_q];
  assign head_data  = fifo_data[rd_ptr_q];

  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != StIdle) || !fifo_empty;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr_q]   <= bus.cmd_op;
      fifo_data[wr_ptr_q] <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      reg_r       <= 1'b0;
      reg_w       <= 1'b0;
      reg_ip      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_cnt    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // NOPs are popped and dropped without leaving IDLE.
          if (pop && head_op != OpNop) begin
            op_q    <= head_op;
            // Strobes are loaded here so they are high for exactly the ISSUE cycle.
            reg_r   <= (head_op == OpRead) || (head_op == OpSwap);
            reg_w   <= (head_op == OpWrite) || (head_op == OpSwap);
            if (head_op == OpWrite || head_op == OpSwap) reg_ip <= head_data;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          reg_r <= 1'b0;
          reg_w <= 1'b0;
          if (op_q == OpWrite) begin
            done_cnt <= done_cnt + 8'd1;
            state_q  <= StIdle;
          end else begin
            state_q <= StCapt;
          end
        end
        StCapt: begin
          // reg_op was loaded on the ISSUE edge, before any SWAP write landed.
          rsp_data_q  <= reg_op;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            done_cnt    <= done_cnt + 8'd1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
